imm_ext_arbiter: RTL and testbench

- Shares a single immediate-extraction/sign-extension datapath between two requesters:
  - requester 0: decode stage.
  - requester 1: early-branch target unit in fetch.
- Decodes the LEGv8 instruction format, extracts the immediate field and extends it to 64 bits.
- Registers the result in a 1-deep output buffer with a valid/ready handshake.
- Arbitration between simultaneous requests is round-robin. A flush input drops buffered results.

---
 rtl/imm_ext_arbiter.sv | 147 ++++++++++++++
 tb/tb_imm_ext_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter
//
// Purpose:
//   Shares one LEGv8 immediate-extraction / sign-extension datapath between
//   two requesters (0 = decode stage, 1 = early-branch target unit in fetch).
//   The winner's instruction is decoded and its immediate is extended to
//   64 bits. The result is registered in a 1-deep output buffer.
//   Simultaneous requests are arbitrated round-robin, and a flush drops the
//   buffered result.
//
// Handshake semantics (every valid/ready pair in this block):
//   A transfer happens on a rising edge where valid and ready are both 1.
//   - A requester holds valid and its instruction stable until it sees ready.
//   - reqN_ready is a combinational grant. It depends on reqN_valid, so it is
//     only meaningful while the requester is presenting valid.
//   - out_valid stays high with stable out_imm/out_fmt/out_id until out_ready
//     is sampled high. A flush is the one exception: it withdraws the result.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset (0 = reset)
//   req0_valid   requester 0 presents an instruction
//   req0_instr   requester 0 instruction word
//   req0_ready   requester 0 granted this cycle
//   req1_valid   requester 1 presents an instruction
//   req1_instr   requester 1 instruction word
//   req1_ready   requester 1 granted this cycle
//   flush        drop the buffered result; block grants this cycle
//   out_valid    output buffer holds a result
//   out_ready    consumer accepts the result
//   out_imm      extended immediate
//   out_fmt      format: 0 NONE, 1 I, 2 D, 3 CB, 4 B
//   out_id       requester that produced the result
//   dbg_rr_ptr   current round-robin pointer (debug visibility)

module imm_ext_arbiter #(
  parameter int DATA_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_valid,
  input  logic [INSTR_WIDTH-1:0] req0_instr,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [INSTR_WIDTH-1:0] req1_instr,
  output logic                   req1_ready,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_imm,
  output logic [2:0]             out_fmt,
  output logic                   out_id,
  output logic                   dbg_rr_ptr
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_D    = 3'd2;
  localparam logic [2:0] FMT_CB   = 3'd3;
  localparam logic [2:0] FMT_B    = 3'd4;

  logic                   rr_ptr;
  logic                   free;
  logic                   any_grant;
  logic                   grant_id;
  logic [INSTR_WIDTH-1:0] sel_instr;
  logic [2:0]             dec_fmt;
  logic [DATA_WIDTH-1:0]  dec_imm;

  assign dbg_rr_ptr = rr_ptr;

  // A result draining this cycle frees the buffer, so a new grant can load
  // on the same edge.
  assign free = !out_valid || out_ready;

  always_comb begin
    any_grant = 1'b0;
    grant_id  = 1'b0;
    if (free && !flush) begin
      if (req0_valid && req1_valid) begin
        any_grant = 1'b1;
        grant_id  = rr_ptr;
      end else if (req0_valid) begin
        any_grant = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid) begin
        any_grant = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  // The buffer looks free while reset is held, so the grants are gated
  // with reset to keep both readies low during reset.
  assign req0_ready = reset && any_grant && !grant_id;
  assign req1_ready = reset && any_grant &&  grant_id;

  assign sel_instr = grant_id ? req1_instr : req0_instr;

  // Decode the formats in priority order; the first match wins. No shift is
  // applied to branch offsets, because the branch adder does the scaling.
  always_comb begin
    dec_fmt = FMT_NONE;
    dec_imm = '0;
    if (sel_instr[31:26] == 6'b000101) begin
      dec_fmt = FMT_B;
      dec_imm = {{(DATA_WIDTH-26){sel_instr[25]}}, sel_instr[25:0]};
    end else if (sel_instr[31:24] == 8'b10110100 ||
                 sel_instr[31:24] == 8'b10110101 ||
                 sel_instr[31:24] == 8'b01010100) begin
      dec_fmt = FMT_CB;
      dec_imm = {{(DATA_WIDTH-19){sel_instr[23]}}, sel_instr[23:5]};
    end else if (sel_instr[31:21] == 11'b11111000010 ||
                 sel_instr[31:21] == 11'b11111000000) begin
      dec_fmt = FMT_D;
      dec_imm = {{(DATA_WIDTH-9){sel_instr[20]}}, sel_instr[20:12]};
    end else if (sel_instr[31:22] == 10'b1001000100 ||
                 sel_instr[31:22] == 10'b1101000100) begin
      dec_fmt = FMT_I;
      dec_imm = {{(DATA_WIDTH-12){1'b0}}, sel_instr[21:10]};
    end
  end

  // Output buffer and round-robin pointer. When a result drains and nothing
  // new loads, only out_valid drops; the payload keeps its last value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_imm   <= '0;
      out_fmt   <= FMT_NONE;
      out_id    <= 1'b0;
      rr_ptr    <= 1'b0;
    end else begin
      if (any_grant) begin
        out_valid <= 1'b1;
        out_imm   <= dec_imm;
        out_fmt   <= dec_fmt;
        out_id    <= grant_id;
        rr_ptr    <= ~grant_id;
      end else if (flush || out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
module tb_imm_ext_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid;
  logic [31:0] req0_instr;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_instr;
  logic        req1_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_id;
  logic        dbg_rr_ptr;

  int total;
  int passed;

  imm_ext_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_instr (req0_instr),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_instr (req1_instr),
    .req1_ready (req1_ready),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_imm    (out_imm),
    .out_fmt    (out_fmt),
    .out_id     (out_id),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // Clock and time limit.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got time %0t required < 200000", $time);
    $fatal(1);
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_instr = '0;
    req1_instr = '0;
    flush      = 1'b0;
    out_ready  = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset      = 1'b0;
    req0_valid = 1'b1;
    req0_instr = 32'h913F_FC00;
    step();
    step();
    total++; if (req0_ready !== 1'b0) $display("FAIL reset_req0_ready: got %b want 0", req0_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (out_imm !== 64'h0) $display("FAIL reset_out_imm: got %h want 0", out_imm); else passed++;
    total++; if (out_fmt !== 3'd0) $display("FAIL reset_out_fmt: got %0d want 0", out_fmt); else passed++;
    // Release between edges.
    #3 reset = 1'b1;
    #1;
    total++; if (req0_ready !== 1'b1) $display("FAIL post_reset_req0_ready: got %b want 1", req0_ready); else passed++;
    step();
    total++; if (out_valid !== 1'b1) $display("FAIL post_reset_out_valid: got %b want 1", out_valid); else passed++;
    total++; if (out_fmt !== 3'd1) $display("FAIL post_reset_out_fmt: got %0d want 1", out_fmt); else passed++;
    total++; if (out_imm !== 64'h0000_0000_0000_0FFF) $display("FAIL post_reset_out_imm: got %h want 0000000000000fff", out_imm); else passed++;
    total++; if (out_id !== 1'b0) $display("FAIL post_reset_out_id: got %b want 0", out_id); else passed++;
    req0_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL drain_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (out_imm !== 64'h0000_0000_0000_0FFF) $display("FAIL drain_keeps_imm: got %h want 0000000000000fff", out_imm); else passed++;
  endtask

  task automatic test_sign_extension();
    logic [31:0] instr_v [6];
    logic [2:0]  fmt_v   [6];
    logic [63:0] imm_v   [6];
    instr_v[0] = 32'hF85F_F000; fmt_v[0] = 3'd2; imm_v[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    instr_v[1] = 32'hB480_0000; fmt_v[1] = 3'd3; imm_v[1] = 64'hFFFF_FFFF_FFFC_0000;
    instr_v[2] = 32'h1600_0000; fmt_v[2] = 3'd4; imm_v[2] = 64'hFFFF_FFFF_FE00_0000;
    instr_v[3] = 32'h1400_0005; fmt_v[3] = 3'd4; imm_v[3] = 64'h0000_0000_0000_0005;
    instr_v[4] = 32'h0000_0000; fmt_v[4] = 3'd0; imm_v[4] = 64'h0000_0000_0000_0000;
    instr_v[5] = 32'hD100_0400; fmt_v[5] = 3'd1; imm_v[5] = 64'h0000_0000_0000_0001;
    idle_inputs();
    req0_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req0_instr = instr_v[i];
      step();
      total++; if (out_valid !== 1'b1) $display("FAIL ext_valid[%0d]: got %b want 1", i, out_valid); else passed++;
      total++; if (out_fmt !== fmt_v[i]) $display("FAIL ext_fmt[%0d]: got %0d want %0d", i, out_fmt, fmt_v[i]); else passed++;
      total++; if (out_imm !== imm_v[i]) $display("FAIL ext_imm[%0d]: got %h want %h", i, out_imm, imm_v[i]); else passed++;
      total++; if (out_id !== 1'b0) $display("FAIL ext_id[%0d]: got %b want 0", i, out_id); else passed++;
    end
    req0_valid = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    logic exp_id;
    idle_inputs();
    req0_instr = 32'h1400_0001;
    req1_instr = 32'h1400_0002;
    // A lone requester 1 grant leaves the pointer at 0.
    req1_valid = 1'b1;
    #1;
    total++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) $display("FAIL rr_solo_ready: got r0=%b r1=%b want r0=0 r1=1", req0_ready, req1_ready); else passed++;
    step();
    total++; if (out_id !== 1'b1 || out_imm !== 64'h2) $display("FAIL rr_solo_out: got id=%b imm=%h want id=1 imm=2", out_id, out_imm); else passed++;
    req0_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_id = (i % 2 == 1);
      #1;
      total++; if (req0_ready !== !exp_id || req1_ready !== exp_id) $display("FAIL rr_ready[%0d]: got r0=%b r1=%b want grant %0d", i, req0_ready, req1_ready, exp_id); else passed++;
      step();
      total++; if (out_valid !== 1'b1 || out_id !== exp_id) $display("FAIL rr_out_id[%0d]: got v=%b id=%b want v=1 id=%b", i, out_valid, out_id, exp_id); else passed++;
      total++; if (out_imm !== (exp_id ? 64'h2 : 64'h1)) $display("FAIL rr_out_imm[%0d]: got %h want %h", i, out_imm, exp_id ? 64'h2 : 64'h1); else passed++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    idle_inputs();
    req0_valid = 1'b1;
    req0_instr = 32'hF85F_F000;
    step();
    req0_valid = 1'b0;
    out_ready  = 1'b0;
    req1_valid = 1'b1;
    req1_instr = 32'h1400_0005;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL bp_ready[%0d]: got r0=%b r1=%b want both 0", i, req0_ready, req1_ready); else passed++;
      total++; if (out_valid !== 1'b1 || out_fmt !== 3'd2 || out_imm !== 64'hFFFF_FFFF_FFFF_FFFF || out_id !== 1'b0)
        $display("FAIL bp_hold[%0d]: got v=%b fmt=%0d imm=%h id=%b want v=1 fmt=2 imm=ffffffffffffffff id=0", i, out_valid, out_fmt, out_imm, out_id);
      else passed++;
      step();
    end
    out_ready = 1'b1;
    #1;
    total++; if (req1_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", req1_ready); else passed++;
    step();
    total++; if (out_valid !== 1'b1 || out_fmt !== 3'd4 || out_imm !== 64'h5 || out_id !== 1'b1)
      $display("FAIL bp_reload: got v=%b fmt=%0d imm=%h id=%b want v=1 fmt=4 imm=5 id=1", out_valid, out_fmt, out_imm, out_id);
    else passed++;
    req1_valid = 1'b0;
    step();
  endtask

  task automatic test_flush();
    idle_inputs();
    // Grant requester 0 so the pointer moves to 1.
    req0_valid = 1'b1;
    req0_instr = 32'h913F_FC00;
    step();
    out_ready  = 1'b0;
    flush      = 1'b1;
    req1_valid = 1'b1;
    req1_instr = 32'h1400_0003;
    #1;
    total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL flush_ready: got r0=%b r1=%b want both 0", req0_ready, req1_ready); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b want 0", out_valid); else passed++;
    flush = 1'b0;
    #1;
    // Pointer untouched by the flush, so requester 1 wins the tie.
    total++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) $display("FAIL flush_rr_ptr: got r0=%b r1=%b want r0=0 r1=1", req0_ready, req1_ready); else passed++;
    step();
    total++; if (out_valid !== 1'b1 || out_id !== 1'b1 || out_imm !== 64'h3) $display("FAIL flush_regrant: got v=%b id=%b imm=%h want v=1 id=1 imm=3", out_valid, out_id, out_imm); else passed++;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready  = 1'b1;
    step();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    req0_valid = 1'b1;
    req0_instr = 32'h913F_FC00;
    step();
    out_ready  = 1'b0;
    req1_valid = 1'b1;
    req1_instr = 32'h1400_0007;
    #2 reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_fmt !== 3'd0 || out_imm !== 64'h0 || out_id !== 1'b0)
      $display("FAIL async_reset_out: got v=%b fmt=%0d imm=%h id=%b want all 0", out_valid, out_fmt, out_imm, out_id);
    else passed++;
    total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL async_reset_ready: got r0=%b r1=%b want both 0", req0_ready, req1_ready); else passed++;
    step();
    #2 reset = 1'b1;
    #1;
    // Pointer back at 0 after reset, so requester 0 wins the tie.
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL async_rearb_ready: got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready); else passed++;
    step();
    total++; if (out_valid !== 1'b1 || out_id !== 1'b0 || out_fmt !== 3'd1) $display("FAIL async_rearb_out: got v=%b id=%b fmt=%0d want v=1 id=0 fmt=1", out_valid, out_id, out_fmt); else passed++;
    idle_inputs();
    step();
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_sign_extension();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
